iob_countdown_timer: RTL
========================

# iob_countdown_timer

Loadable down-counter with terminal-count detection, the decrementing counterpart to the free-running up-counter used throughout the cache datapath. It is loaded with an initial count, decrements on each enabled cycle, and raises a one-cycle terminal-count pulse when it reaches zero. On zero it either stops in a done state or auto-reloads the last loaded value. Cache control logic uses it for timeouts, refresh intervals and burst-length tracking.

## Interface

Parameters:

- `DATA_W`, default 21: counter width in bits.
- `RST_VAL`, default `{DATA_W{1'b0}}`: value of `data_o` after reset.

Ports:

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `cke_i`  input  1  clock enable; when low, all registers hold.
- `rst_i`  input  1  synchronous, active-high reset.
- `load_i`  input  1  load `load_val_i` into the counter and reload register.
- `load_val_i`  input  DATA_W  initial count.
- `en_i`  input  1  decrement enable.
- `reload_i`  input  1  level; auto-reload mode, sampled at terminal count.
- `data_o`  output  DATA_W  current count, registered.
- `busy_o`  output  1  registered; 1 in RUN.
- `done_o`  output  1  registered; 1 in DONE.
- `tc_o`  output  1  registered one-cycle terminal-count pulse.

## Operation

- States:
  - IDLE: after reset, nothing loaded.
  - RUN: counting, `data_o` is greater than 0.
  - DONE: reached zero, not reloaded.
- Internal reload register `rld`, DATA_W bits, holds the last loaded value.
- Clock enable:
  - Every register, including the effect of `rst_i`, updates only on edges where `cke_i` = 1.
  - With `cke_i` = 0, all outputs hold, including a pending `tc_o`.
- Priority on an edge with `cke_i` = 1: `rst_i` first, then `load_i`, then `en_i`.
- Reset:
  - state goes to IDLE.
  - `data_o` = `RST_VAL`, `rld` = `RST_VAL`.
  - `busy_o` = 0, `done_o` = 0, `tc_o` = 0.
- Load, any state:
  - `data_o` = `load_val_i`, `rld` = `load_val_i`, `tc_o` = 0.
  - If `load_val_i` is non-zero, state goes to RUN.
  - If `load_val_i` = 0, state goes to DONE with no `tc_o` pulse.
  - A load during RUN aborts the current count and restarts it; no `tc_o` is produced.
- Decrement in RUN with `en_i` = 1 and `data_o` greater than 1:
  - `data_o` = `data_o` − 1.
  - `tc_o` = 0.
- Terminal count in RUN with `en_i` = 1 and `data_o` = 1:
  - `tc_o` = 1 on the next cycle.
  - If `reload_i` = 1: `data_o` = `rld` and state stays RUN. `rld` is never 0 in RUN.
  - If `reload_i` = 0: `data_o` = 0 and state goes to DONE.
- `en_i` = 0 in RUN: `data_o` holds and `tc_o` = 0.
- `en_i` in IDLE or DONE is ignored:
  - no decrement, no wrap below zero.
  - `data_o` holds and `tc_o` = 0.
- Arithmetic is unsigned DATA_W. Saturation comes from the state machine, so no wider adder is needed.

## Timing

- Load accepted at edge N: after edge N, `data_o` = `load_val_i`, `busy_o` = 1 (or `done_o` = 1 for a zero load).
- Latency from load of value V with `en_i` held high to `tc_o`:
  - `tc_o` is high during the cycle after the V-th enabled edge following the load edge.
  - `busy_o` falls on that same edge in non-reload mode.
- `tc_o` lasts one cycle, or longer only while `cke_i` = 0 freezes it.
- Auto-reload period with `en_i` held high is V cycles, with no dead cycle between periods.
- Simultaneous `load_i` and terminal count: the load wins and `tc_o` stays 0.
- Simultaneous `rst_i` with any input: reset values apply.
- Outputs are fully registered; there is no combinational path from input to output.

## Test plan

- Reset: assert `rst_i` with `cke_i` = 1 → `data_o` = 0, `busy_o` = 0, `done_o` = 0, `tc_o` = 0. Then pulse `en_i` for 5 cycles → `data_o` stays 0.
- One-shot: load 3, `en_i` = 1, `reload_i` = 0 →
  - `data_o` sequence is 3, 2, 1, 0.
  - `tc_o` = 1 exactly in the cycle `data_o` first reads 0, then `done_o` = 1 and `busy_o` = 0.
  - 4 further `en_i` cycles → `data_o` stays 0, no new `tc_o`.
- Auto-reload: load 4, `reload_i` = 1, `en_i` = 1 for 12 cycles → `data_o` sequence is 4, 3, 2, 1, 4, 3, 2, 1, 4, …, with `tc_o` pulses 4 cycles apart and `busy_o` constantly 1.
- Clock-enable freeze: load 2, then cycles with `en_i` = 1 while `cke_i` toggles 1, 0, 0, 1 → `data_o` changes only on `cke_i` = 1 edges. A `tc_o` asserted before `cke_i` drops holds until the next enabled edge.
- Boundaries:
  - load 0 → `done_o` = 1 immediately, `tc_o` never asserts.
  - load `{DATA_W{1'b1}}` then 1 decrement → `data_o` = 2^DATA_W − 2.
  - load 5 on the same edge as a terminal count from value 1 → `data_o` = 5, `tc_o` = 0.
- Reset mid-count: load 10, decrement 4 times, assert `rst_i` → next cycle `data_o` = `RST_VAL`, IDLE state, `rld` cleared. A subsequent `en_i` has no effect.

Source files
------------

// File: rtl/iob_countdown_timer.sv
// iob_countdown_timer: loadable down-counter with a terminal-count pulse.
// It either stops in DONE at zero or auto-reloads the last loaded value.
// All outputs are registered, and every register is gated by cke_i.
module iob_countdown_timer #(
   parameter int                  DATA_W  = 21,
   parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_val_i,
   input  logic              en_i,
   input  logic              reload_i,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              tc_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_rld;
   logic              r_busy;
   logic              r_done;
   logic              r_tc;

   logic              w_at_one;

   assign w_at_one = (r_data == DATA_W'(1));

   // State machine, counter, reload register and registered flags.
   // Priority order is reset, then load, then decrement.
   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (rst_i) begin
            r_state <= S_IDLE;
            r_data  <= RST_VAL;
            r_rld   <= RST_VAL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tc    <= 1'b0;
         end else if (load_i) begin
            r_data <= load_val_i;
            r_rld  <= load_val_i;
            r_tc   <= 1'b0;
            if (load_val_i != '0) begin
               r_state <= S_RUN;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
            end else begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
         end else begin
            r_tc <= 1'b0;
            if (r_state == S_RUN && en_i) begin
               if (w_at_one) begin
                  r_tc <= 1'b1;
                  if (reload_i) begin
                     r_data <= r_rld;
                  end else begin
                     r_data  <= '0;
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_data <= r_data - DATA_W'(1);
               end
            end
         end
      end
   end

   assign data_o = r_data;
   assign busy_o = r_busy;
   assign done_o = r_done;
   assign tc_o   = r_tc;

endmodule
